// File: rtl/mult_pkg.sv
// Shared types and helpers for the multiplier arbiter.
package mult_pkg;

  localparam int DEF_WIDTH = 8;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT,
    RELEASE,
    RESPOND
  } state_t;

  // Index width for a requester count, never below one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mult_arbiter_if.sv
// Start/done handshake and operand/product bus to the shared multiplier.
interface mult_arbiter_if import mult_pkg::*; #(
  parameter int WIDTH = DEF_WIDTH
);
  logic                 mult_start;
  logic [WIDTH-1:0]     mult_a;
  logic [WIDTH-1:0]     mult_b;
  logic                 mult_done;
  logic [2*WIDTH-1:0]   mult_prod;

  modport master (output mult_start, mult_a, mult_b, input mult_done, mult_prod);
  modport slave  (input mult_start, mult_a, mult_b, output mult_done, mult_prod);
endinterface

// File: rtl/mult_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or after rr_ptr, wrapping.
module rr_pick import mult_pkg::*; #(
  parameter int N_REQ = 4,
  parameter int IDXW  = idx_w(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDXW-1:0]  rr_ptr,
  output logic             any,
  output logic [IDXW-1:0]  idx
);

  int j;

  // Scan from farthest to nearest so the nearest hit is assigned last.
  always_comb begin
    any = 1'b0;
    idx = '0;
    j   = 0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      j = (int'(rr_ptr) + k) % N_REQ;
      if (req[IDXW'(j)]) begin
        any = 1'b1;
        idx = IDXW'(j);
      end
    end
  end

endmodule

// File: rtl/mult_arbiter.sv
// Round-robin arbiter sharing one sequential multiplier among N_REQ requesters,
// with a sticky watchdog for a multiplier that never raises done.
module mult_arbiter import mult_pkg::*; #(
  parameter int N_REQ   = 4,
  parameter int WIDTH   = DEF_WIDTH,
  parameter int TIMEOUT = 64
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ*WIDTH-1:0] op_a,
  input  logic [N_REQ*WIDTH-1:0] op_b,
  output logic [N_REQ-1:0]       gnt,
  output logic [N_REQ-1:0]       rsp_valid,
  output logic [2*WIDTH-1:0]     rsp_data,
  output logic                   busy,
  output logic                   err,
  mult_arbiter_if.master         mult
);

  localparam int IDXW = idx_w(N_REQ);
  localparam int WDW  = $clog2(TIMEOUT + 1);

  state_t              state, state_nxt;
  logic [IDXW-1:0]     idx_q, idx_nxt, rr_ptr, rr_ptr_nxt;
  logic [WIDTH-1:0]    a_q, a_nxt, b_q, b_nxt, a_sel, b_sel;
  logic [2*WIDTH-1:0]  result_q, result_nxt, rsp_q, rsp_nxt;
  logic [WDW-1:0]      wdog, wdog_nxt;
  logic                err_q, err_nxt;
  logic                pick_any;
  logic [IDXW-1:0]     pick_idx;

  rr_pick #(.N_REQ(N_REQ), .IDXW(IDXW)) u_pick (
    .req    (req),
    .rr_ptr (rr_ptr),
    .any    (pick_any),
    .idx    (pick_idx)
  );

  always_comb begin
    a_sel = '0;
    b_sel = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (pick_idx == IDXW'(i)) begin
        a_sel = op_a[i*WIDTH +: WIDTH];
        b_sel = op_b[i*WIDTH +: WIDTH];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      idx_q    <= '0;
      rr_ptr   <= '0;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
      rsp_q    <= '0;
      wdog     <= '0;
      err_q    <= 1'b0;
    end else begin
      state    <= state_nxt;
      idx_q    <= idx_nxt;
      rr_ptr   <= rr_ptr_nxt;
      a_q      <= a_nxt;
      b_q      <= b_nxt;
      result_q <= result_nxt;
      rsp_q    <= rsp_nxt;
      wdog     <= wdog_nxt;
      err_q    <= err_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    idx_nxt    = idx_q;
    rr_ptr_nxt = rr_ptr;
    a_nxt      = a_q;
    b_nxt      = b_q;
    result_nxt = result_q;
    rsp_nxt    = rsp_q;
    wdog_nxt   = wdog;
    err_nxt    = err_q;
    case (state)
      IDLE: begin
        if (pick_any) begin
          idx_nxt   = pick_idx;
          a_nxt     = a_sel;
          b_nxt     = b_sel;
          state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        wdog_nxt  = '0;
        state_nxt = WAIT;
      end
      WAIT: begin
        if (mult.mult_done) begin
          result_nxt = mult.mult_prod;
          state_nxt  = RELEASE;
        end else if (wdog == WDW'(TIMEOUT - 1)) begin
          // Watchdog expiry: respond with a zero product rather than hang the requester.
          err_nxt    = 1'b1;
          result_nxt = '0;
          state_nxt  = RELEASE;
        end else begin
          wdog_nxt = wdog + 1'b1;
        end
      end
      RELEASE: begin
        if (!mult.mult_done) begin
          rsp_nxt   = result_q;
          state_nxt = RESPOND;
        end
      end
      RESPOND: begin
        rr_ptr_nxt = (idx_q == IDXW'(N_REQ - 1)) ? '0 : idx_q + 1'b1;
        state_nxt  = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign busy            = (state != IDLE);
  assign gnt             = busy ? (N_REQ'(1) << idx_q) : '0;
  assign rsp_valid       = (state == RESPOND) ? (N_REQ'(1) << idx_q) : '0;
  assign rsp_data        = rsp_q;
  assign err             = err_q;
  assign mult.mult_start = (state == ISSUE) || (state == WAIT);
  assign mult.mult_a     = a_q;
  assign mult.mult_b     = b_q;

endmodule

// File: tb/tb_mult_arbiter.sv
// Bench for mult_arbiter: vector table, directed corner sequences and a randomized
// run against a round-robin reference model, with a behavioural multiplier stub.
module tb_mult_arbiter;

  localparam int N   = 4;
  localparam int W   = 8;
  localparam int LAT = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic [N-1:0]     req;
  logic [N*W-1:0]   op_a, op_b;
  logic [N-1:0]     gnt, rsp_valid;
  logic [2*W-1:0]   rsp_data;
  logic             busy, err;
  logic             dead;

  mult_arbiter_if #(.WIDTH(W)) mif ();

  mult_arbiter #(.N_REQ(N), .WIDTH(W), .TIMEOUT(64)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .op_a      (op_a),
    .op_b      (op_b),
    .gnt       (gnt),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .busy      (busy),
    .err       (err),
    .mult      (mif)
  );

  always #5 clk = ~clk;

  // Multiplier stub: loads on start, finishes LAT+1 cycles later, holds done until start drops.
  logic        m_run;
  int          m_cnt;
  logic [15:0] m_a, m_b;
  always @(posedge clk) begin
    if (rst) begin
      m_run <= 1'b0;
      m_cnt <= 0;
      mif.mult_done <= 1'b0;
      mif.mult_prod <= '0;
    end else if (!m_run && !mif.mult_done && mif.mult_start && !dead) begin
      m_run <= 1'b1;
      m_cnt <= LAT;
      m_a   <= {8'h00, mif.mult_a};
      m_b   <= {8'h00, mif.mult_b};
    end else if (m_run) begin
      if (m_cnt == 0) begin
        m_run <= 1'b0;
        mif.mult_done <= 1'b1;
        mif.mult_prod <= m_a * m_b;
      end else begin
        m_cnt <= m_cnt - 1;
      end
    end else if (mif.mult_done && !mif.mult_start) begin
      mif.mult_done <= 1'b0;
    end
  end

  int n_pass = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0d exp=%0d", name, got, exp);
  endtask

  task automatic set_ops(input int i, input logic [7:0] a, input logic [7:0] b);
    op_a[i*W +: W] = a;
    op_b[i*W +: W] = b;
  endtask

  task automatic pulse_rst();
    @(negedge clk);
    rst = 1'b1;
    req = '0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wait_rsp(input int bound, output int who, output logic [15:0] data,
                          output int cyc);
    bit gbad;
    who = -1; data = '0; cyc = 0; gbad = 0;
    for (int c = 1; c <= bound; c++) begin
      @(negedge clk);
      if ($countones(gnt) > 1) gbad = 1;
      if (rsp_valid != '0) begin
        cyc  = c;
        data = rsp_data;
        for (int i = 0; i < N; i++) if (rsp_valid[i]) who = i;
        chk("rsp_onehot", $countones(rsp_valid), 1);
        break;
      end
    end
    chk("gnt_onehot", {31'b0, gbad}, 0);
    if (cyc == 0) begin
      n_total++;
      $display("FAIL rsp_wait got=none exp=rsp_valid within %0d cycles", bound);
    end
  endtask

  typedef struct {
    logic [N-1:0] rq;
    logic [7:0]   a;
    logic [7:0]   b;
    int           idx;
    logic [15:0]  prod;
  } vec_t;

  vec_t vecs[5];

  int          who, cyc;
  logic [15:0] data;
  int          ptr_m;
  bit          pend[N];
  logic [7:0]  ra[N], rb[N];

  initial begin
    vecs[0] = '{rq: 4'b0001, a: 8'd5,   b: 8'd7,   idx: 0, prod: 16'd35};
    vecs[1] = '{rq: 4'b0010, a: 8'd255, b: 8'd255, idx: 1, prod: 16'd65025};
    vecs[2] = '{rq: 4'b0100, a: 8'd200, b: 8'd0,   idx: 2, prod: 16'd0};
    vecs[3] = '{rq: 4'b1000, a: 8'd0,   b: 8'd255, idx: 3, prod: 16'd0};
    vecs[4] = '{rq: 4'b0001, a: 8'd12,  b: 8'd13,  idx: 0, prod: 16'd156};

    rst = 1'b1; req = '0; op_a = '0; op_b = '0; dead = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_gnt", gnt, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_data", rsp_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", err, 0);
    chk("rst_start", mif.mult_start, 0);
    chk("rst_mult_a", mif.mult_a, 0);
    chk("rst_mult_b", mif.mult_b, 0);
    rst = 1'b0;

    // Single-request vectors, other slices filled with noise to expose slice selection.
    for (int v = 0; v < 5; v++) begin
      @(negedge clk);
      op_a = $urandom; op_b = $urandom;
      set_ops(vecs[v].idx, vecs[v].a, vecs[v].b);
      req = vecs[v].rq;
      @(negedge clk);
      chk("vec_gnt", gnt, 32'(vecs[v].rq));
      chk("vec_start", mif.mult_start, 1);
      chk("vec_mult_a", mif.mult_a, vecs[v].a);
      chk("vec_mult_b", mif.mult_b, vecs[v].b);
      wait_rsp(200, who, data, cyc);
      chk("vec_who", who, vecs[v].idx);
      chk("vec_data", data, vecs[v].prod);
      if (v == 0) chk("vec_latency", cyc, LAT + 5);
      req = '0;
      @(negedge clk);
      chk("vec_busy_after", busy, 0);
      chk("vec_rsp_cleared", rsp_valid, 0);
      chk("vec_data_hold", rsp_data, vecs[v].prod);
    end

    // Contention from reset: 0 then 2, then rr_ptr=3 makes 3 win over 0.
    pulse_rst();
    set_ops(0, 8'd3, 8'd4); set_ops(2, 8'd6, 8'd7);
    req = 4'b0101;
    wait_rsp(200, who, data, cyc);
    chk("cont1_who", who, 0); chk("cont1_data", data, 12);
    req[0] = 1'b0;
    wait_rsp(200, who, data, cyc);
    chk("cont2_who", who, 2); chk("cont2_data", data, 42);
    set_ops(3, 8'd2, 8'd50);
    req = 4'b1001;
    wait_rsp(200, who, data, cyc);
    chk("cont3_who", who, 3); chk("cont3_data", data, 100);
    req[3] = 1'b0;
    wait_rsp(200, who, data, cyc);
    chk("cont4_who", who, 0); chk("cont4_data", data, 12);
    req = '0;

    // Fairness with all requesters continuously re-requesting.
    pulse_rst();
    for (int i = 0; i < N; i++) set_ops(i, 8'(i + 1), 8'(i + 10));
    req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      wait_rsp(200, who, data, cyc);
      chk("fair_who", who, k % N);
      chk("fair_data", data, ((k % N) + 1) * ((k % N) + 10));
      if (who >= 0) req[who] = 1'b0;
      @(negedge clk);
      req = 4'b1111;
    end
    req = '0;

    // Reset while waiting on the multiplier aborts without a response.
    pulse_rst();
    set_ops(1, 8'd10, 8'd11);
    req = 4'b0010;
    repeat (3) @(negedge clk);
    chk("abort_in_wait", mif.mult_start, 1);
    rst = 1'b1; req = '0;
    @(negedge clk);
    chk("abort_gnt", gnt, 0);
    chk("abort_busy", busy, 0);
    chk("abort_rsp_valid", rsp_valid, 0);
    chk("abort_start", mif.mult_start, 0);
    chk("abort_mult_a", mif.mult_a, 0);
    chk("abort_rsp_data", rsp_data, 0);
    rst = 1'b0;
    set_ops(2, 8'd9, 8'd8);
    req = 4'b0100;
    wait_rsp(200, who, data, cyc);
    chk("abort_next_who", who, 2); chk("abort_next_data", data, 72);
    req = '0;

    // Dead multiplier: watchdog fires after 64 WAIT cycles, zero product, sticky err.
    dead = 1'b1;
    pulse_rst();
    set_ops(1, 8'd9, 8'd9);
    req = 4'b0010;
    wait_rsp(200, who, data, cyc);
    chk("wd_cycles", cyc, 67);
    chk("wd_who", who, 1);
    chk("wd_data", data, 0);
    chk("wd_err", err, 1);
    req = '0; dead = 1'b0;
    @(negedge clk);
    set_ops(0, 8'd4, 8'd4);
    req = 4'b0001;
    wait_rsp(200, who, data, cyc);
    chk("wd_after_data", data, 16);
    chk("wd_err_sticky", err, 1);
    req = '0;
    pulse_rst();
    chk("wd_err_cleared", err, 0);

    // Randomized traffic against a round-robin reference model.
    pulse_rst();
    ptr_m = 0;
    for (int i = 0; i < N; i++) begin
      pend[i] = ($urandom_range(1, 0) == 1);
      ra[i] = 8'($urandom); rb[i] = 8'($urandom);
    end
    pend[$urandom_range(N - 1, 0)] = 1'b1;
    for (int i = 0; i < N; i++) begin
      set_ops(i, ra[i], rb[i]);
      req[i] = pend[i];
    end
    for (int t = 0; t < 40; t++) begin
      int ew;
      bit any;
      ew = -1;
      for (int k = N - 1; k >= 0; k--) if (pend[(ptr_m + k) % N]) ew = (ptr_m + k) % N;
      wait_rsp(200, who, data, cyc);
      chk("rnd_who", who, ew);
      chk("rnd_data", data, 32'(ra[ew]) * 32'(rb[ew]));
      pend[ew] = 1'b0;
      ptr_m = (ew + 1) % N;
      any = 0;
      for (int i = 0; i < N; i++) begin
        if (i != ew && !pend[i] && $urandom_range(1, 0) == 1) begin
          pend[i] = 1'b1;
          ra[i] = 8'($urandom); rb[i] = 8'($urandom);
          set_ops(i, ra[i], rb[i]);
        end
        any |= pend[i];
      end
      for (int i = 0; i < N; i++) req[i] = pend[i];
      if (!any) begin
        int r;
        @(negedge clk);
        r = $urandom_range(N - 1, 0);
        pend[r] = 1'b1;
        ra[r] = 8'($urandom); rb[r] = 8'($urandom);
        set_ops(r, ra[r], rb[r]);
        req[r] = 1'b1;
      end
    end
    req = '0;
    repeat (2) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/mult_arbiter.md
Name: mult_arbiter

Overview:
Shares one sequential shift-and-add multiplier (datapath plus control unit) between N_REQ requesters. The block selects a requester round-robin and registers its operands onto the multiplier inputs. It then drives the multiplier's start/done handshake to completion and returns the product to the winner with a one-cycle valid pulse. A watchdog flags a multiplier that never completes.

Parameters:
N_REQ, 4, number of requesters (>=1)
WIDTH, 8, operand width; product is 2*WIDTH
TIMEOUT, 64, max cycles mult_done may stay low after issue before err sets

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous, active-high reset; also tied to multiplier rst
req  in  N_REQ  per-requester request, level
op_a  in  N_REQ*WIDTH  packed multiplicands, slice i = requester i
op_b  in  N_REQ*WIDTH  packed multipliers, slice i = requester i
gnt  out  N_REQ  one-hot, high while requester i owns the multiplier
rsp_valid  out  N_REQ  one-cycle pulse, result ready for requester i
rsp_data  out  2*WIDTH  product, valid when any rsp_valid bit is high
busy  out  1  high in any state other than IDLE
err  out  1  sticky watchdog flag, cleared only by rst
mult_start  out  1  start to multiplier control unit
mult_a  out  WIDTH  registered multiplicand to datapath
mult_b  out  WIDTH  registered multiplier to datapath
mult_done  in  1  done from multiplier control unit
mult_prod  in  2*WIDTH  product register of datapath

Behaviour:
- Reset: state=IDLE, rr_ptr=0, gnt=0, rsp_valid=0, rsp_data=0, mult_a=mult_b=0, mult_start=0, busy=0, err=0, wdog=0.
- Reset mid-operation aborts with no response pulse. The multiplier is reset in the same cycle via the shared rst.
- IDLE: if req!=0, select the winner: the first set bit at or after rr_ptr, wrapping modulo N_REQ.
  - Latch idx, set gnt[idx], register op_a/op_b slice idx into mult_a/mult_b, go ISSUE.
  - If req==0, stay in IDLE.
- ISSUE (1 cycle): mult_start=1, wdog=0, go WAIT. The control unit loads operands on this edge.
- WAIT: mult_start=1, wdog increments each cycle.
  - On mult_done=1: capture mult_prod into the result register, go RELEASE.
  - If wdog reaches TIMEOUT first: set err, drop start, go RELEASE; the result register is set to 0.
- RELEASE: mult_start=0. Stay until mult_done=0 (the control unit returns to idle), then go RESPOND.
- RESPOND (1 cycle):
  - rsp_valid[idx]=1 and rsp_data=result.
  - gnt cleared, rr_ptr=(idx+1) mod N_REQ, go IDLE.
- rsp_data holds its value until the next RESPOND.
- Latency: grant to rsp_valid = multiplier cycles + 4.
- Back-to-back: a new grant may occur the cycle after RESPOND.
- Requester contract:
  - Hold operands stable while gnt is high.
  - Drop req in the rsp_valid cycle; a req still high in IDLE is treated as a new request.
- req[idx] dropping while granted is ignored; the operation completes and the response still pulses.
- mult_a/mult_b change only on the IDLE->ISSUE edge.
- gnt and rsp_valid are each one-hot or zero at all times.
- Multiplication is unsigned and the product is full 2*WIDTH, no truncation.
- N_REQ=1: arbitration degenerates; rr_ptr stays 0.

Decomposition:
- Shared package mult_pkg: state enum (IDLE, ISSUE, WAIT, RELEASE, RESPOND), default WIDTH, helper for index width (clog2 of N_REQ, minimum 1).
- Sub-module rr_pick: combinational round-robin picker with inputs req and rr_ptr, outputs any and idx. Keep it separate so it can be unit-tested alone.
- The FSM, watchdog counter and operand/result registers stay in mult_arbiter.

Test Plan:
- Single request: req=0001, a=5, b=7 -> gnt[0] high through RESPOND; rsp_valid[0] one cycle; rsp_data=35; busy low the next cycle.
- Contention: after rst, req=0101 simultaneously -> requester 0 served first, then 2; rr_ptr=3 after the second response; no overlap of gnt.
- Fairness: req=1111 held, each requester re-asserting after its response -> grant order 0,1,2,3,0; no requester is granted twice before the others.
- Boundaries: a=255, b=255 -> 65025; a=200, b=0 -> 0; a=0, b=255 -> 0.
- Reset in WAIT -> next cycle all outputs at reset values, no rsp_valid; a new request afterwards completes correctly.
- Stubbed multiplier never raising done -> err=1 after 64 WAIT cycles; rsp_valid pulses with rsp_data=0; err stays 1 until rst.
